// File: rtl/spi_arbiter_pkg.sv
// Shared definitions for the SPI arbiter: FSM state encodings, idle chip-select value,
// and the requester-index-to-chip-select decode.
package spiart_defs;

  typedef enum logic [2:0] {
    S_RESET,
    S_IDLE,
    S_SETUP,
    S_START,
    S_WAIT,
    S_HOLD,
    S_GAP
  } state_e;

  localparam logic [1:0] CS_IDLE = 2'b11;

  function automatic logic [1:0] cs_sel(input logic idx);
    return idx ? 2'b01 : 2'b10;
  endfunction

endpackage

// File: rtl/spi_arbiter_if.sv
// Requester-side and SPI-master-side handshake bundle for the SPI arbiter.
// slave = arbiter view, master = environment (clients plus SPI master) view.
interface spi_arbiter_if;
  logic       req0_start;
  logic       req0_lock;
  logic [7:0] req0_tx;
  logic       req0_busy;
  logic [7:0] req0_rx;
  logic       req1_start;
  logic       req1_lock;
  logic [7:0] req1_tx;
  logic       req1_busy;
  logic [7:0] req1_rx;
  logic       spi_start;
  logic [7:0] spi_tx;
  logic       spi_busy;
  logic [7:0] spi_rx;
  logic [1:0] cs_n;
  logic       owner;

  modport slave (
    input  req0_start, req0_lock, req0_tx, req1_start, req1_lock, req1_tx, spi_busy, spi_rx,
    output req0_busy, req0_rx, req1_busy, req1_rx, spi_start, spi_tx, cs_n, owner
  );

  modport master (
    output req0_start, req0_lock, req0_tx, req1_start, req1_lock, req1_tx, spi_busy, spi_rx,
    input  req0_busy, req0_rx, req1_busy, req1_rx, spi_start, spi_tx, cs_n, owner
  );
endinterface

// File: rtl/spi_arb_rr.sv
// Two-way round-robin picker: on contention the requester that did not own the bus last wins.
// Purely combinational.
module spi_arb_rr
  import spiart_defs::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_vld,
  output logic       gnt_idx
);

  always_comb begin
    gnt_vld = |req;
    gnt_idx = 1'b0;
    if (req == 2'b11) begin
      gnt_idx = ~last;
    end else if (req[1]) begin
      gnt_idx = 1'b1;
    end
  end

endmodule

// File: rtl/spi_arbiter.sv
// Shares one SPI master between two byte requesters with per-requester chip selects and locking.
// Start reaches spi_start 2 cycles after a grant in S_IDLE; the losing requester waits with busy low.
module spi_arbiter #(
  parameter int unsigned GAP = 2
) (
  input logic          clk,
  input logic          rst,
  spi_arbiter_if.slave bus
);
  import spiart_defs::*;

  localparam logic [3:0] GAP_LD = 4'(GAP);

  state_e     state_q, state_d;
  logic       owner_q, owner_d;
  logic [1:0] cs_n_q, cs_n_d;
  logic       spi_start_q, spi_start_d;
  logic [7:0] spi_tx_q, spi_tx_d;
  logic [1:0] busy_q, busy_d;
  logic [7:0] rx0_q, rx0_d;
  logic [7:0] rx1_q, rx1_d;
  logic [3:0] gap_q, gap_d;

  logic       gnt_vld;
  logic       gnt_idx;
  logic       arb;
  logic       own_start;
  logic       own_lock;
  logic [7:0] own_tx;

  spi_arb_rr u_rr (
    .req     ({bus.req1_start, bus.req0_start}),
    .last    (owner_q),
    .gnt_vld (gnt_vld),
    .gnt_idx (gnt_idx)
  );

  assign own_start = owner_q ? bus.req1_start : bus.req0_start;
  assign own_lock  = owner_q ? bus.req1_lock  : bus.req0_lock;
  assign own_tx    = owner_q ? bus.req1_tx    : bus.req0_tx;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cs_n_d      = cs_n_q;
    spi_start_d = spi_start_q;
    spi_tx_d    = spi_tx_q;
    busy_d      = busy_q;
    rx0_d       = rx0_q;
    rx1_d       = rx1_q;
    gap_d       = gap_q;
    arb         = 1'b0;

    case (state_q)
      S_RESET: begin
        if (!bus.spi_busy) state_d = S_IDLE;
      end
      S_IDLE: begin
        arb = 1'b1;
      end
      S_SETUP: begin
        spi_start_d = 1'b1;
        state_d     = S_START;
      end
      S_START: begin
        if (bus.spi_busy) begin
          spi_start_d = 1'b0;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!bus.spi_busy) begin
          busy_d[owner_q] = 1'b0;
          if (owner_q) rx1_d = bus.spi_rx;
          else         rx0_d = bus.spi_rx;
          if (own_lock) begin
            state_d = S_HOLD;
          end else begin
            cs_n_d  = CS_IDLE;
            gap_d   = GAP_LD;
            state_d = S_GAP;
          end
        end
      end
      S_HOLD: begin
        if (own_start) begin
          spi_tx_d        = own_tx;
          busy_d[owner_q] = 1'b1;
          spi_start_d     = 1'b1;
          state_d         = S_START;
        end else if (!own_lock) begin
          cs_n_d  = CS_IDLE;
          gap_d   = GAP_LD;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        // Arbitrate in the last gap cycle so CS stays high for exactly GAP cycles.
        if (gap_q <= 4'd1) begin
          state_d = S_IDLE;
          arb     = 1'b1;
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
      default: state_d = S_RESET;
    endcase

    if (arb && gnt_vld) begin
      owner_d         = gnt_idx;
      cs_n_d          = cs_sel(gnt_idx);
      busy_d[gnt_idx] = 1'b1;
      spi_tx_d        = gnt_idx ? bus.req1_tx : bus.req0_tx;
      state_d         = S_SETUP;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_RESET;
      owner_q     <= 1'b1;
      cs_n_q      <= CS_IDLE;
      spi_start_q <= 1'b0;
      spi_tx_q    <= 8'h00;
      busy_q      <= 2'b00;
      rx0_q       <= 8'h00;
      rx1_q       <= 8'h00;
      gap_q       <= 4'd0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cs_n_q      <= cs_n_d;
      spi_start_q <= spi_start_d;
      spi_tx_q    <= spi_tx_d;
      busy_q      <= busy_d;
      rx0_q       <= rx0_d;
      rx1_q       <= rx1_d;
      gap_q       <= gap_d;
    end
  end

  assign bus.req0_busy = busy_q[0];
  assign bus.req1_busy = busy_q[1];
  assign bus.req0_rx   = rx0_q;
  assign bus.req1_rx   = rx1_q;
  assign bus.spi_start = spi_start_q;
  assign bus.spi_tx    = spi_tx_q;
  assign bus.cs_n      = cs_n_q;
  assign bus.owner     = owner_q;

endmodule

// File: doc/spi_arbiter.md
# spi_arbiter

Shares the single SPI master between two byte-level requesters (the UART command bridge on port 0 and an autonomous poller or second bridge on port 1). Grants round-robin per transaction, drives one active-low chip select per requester, and supports locked multi-byte transactions that keep CS asserted across bytes. Each requester sees the same start/busy/tx/rx handshake the SPI master presents, so an existing client attaches without change.

## Interface

- GAP, 2, CS-deasserted idle cycles after a transaction ends before the next grant; legal range 1..15.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- reqN_start (N=0,1)  in  1  level request; held until reqN_busy is seen high.
- reqN_lock  in  1  keep CS and ownership after the current byte.
- reqN_tx  in  8  byte to send; sampled when the byte is granted.
- reqN_busy  out  1  high from grant until reqN_rx is valid.
- reqN_rx  out  8  received byte; valid on the cycle reqN_busy falls and held until that requester's next byte.
- spi_start  out  1  to SPI master.
- spi_tx  out  8  to SPI master.
- spi_busy  in  1  from SPI master.
- spi_rx  in  8  from SPI master.
- cs_n  out  2  cs_n[N] selects requester N's device; never both low.
- owner  out  1  index of the current or last granted requester.

## Operation

- Reset values: spi_start 0, spi_tx 0, req0_busy and req1_busy 0, req0_rx and req1_rx 0, cs_n 2'b11, owner 1, state S_RESET.
- S_RESET: leave for S_IDLE once spi_busy is low. This drains a byte already in flight in the master.
- S_IDLE: arbitrate between the two start inputs.
  - Only one start high: grant it.
  - Both high: grant the requester that is not owner.
  - On grant: owner <= N, cs_n[N] <= 0, reqN_busy <= 1, spi_tx <= reqN_tx, go S_SETUP.
- S_SETUP: one CS setup cycle. spi_start <= 1, go S_START.
- S_START: when spi_busy is high, spi_start <= 0 and go S_WAIT.
- S_WAIT: when spi_busy is low:
  - reqN_rx <= spi_rx and reqN_busy <= 0.
  - If reqN_lock is high, go S_HOLD with CS kept low.
  - Otherwise cs_n <= 2'b11 and go S_GAP.
- S_HOLD: only the owner is served. The other requester's start is ignored; it waits with busy low.
  - Owner start high: spi_tx <= reqN_tx, reqN_busy <= 1, spi_start <= 1, go S_START. No setup cycle is inserted.
  - Owner lock low (start takes priority if both change together): cs_n <= 2'b11, go S_GAP.
- S_GAP: load a 4-bit down-counter with GAP on entry. Go S_IDLE when it expires, giving exactly GAP cycles with both CS high.
- Lock is sampled only in S_WAIT and S_HOLD. A lock held forever starves the other requester; this is intentional and the client is responsible.
- Asserting rst in any state returns all outputs to their reset values immediately and deasserts CS mid-byte. The master byte in progress is then drained by S_RESET.

## Timing

- Request to spi_start latency (start high in S_IDLE at cycle 0): reqN_busy and cs_n low at cycle 1, spi_start high at cycle 2.
- In S_HOLD, the next byte's spi_start is high 1 cycle after start is seen.
- rx to busy: reqN_rx and reqN_busy update in the same cycle, 1 cycle after spi_busy falls.
- Minimum CS-high time between transactions is GAP cycles.
- A start that stays high after busy falls in S_IDLE is treated as a new request. Clients must drop start on seeing busy.

## Structure

- Shared package/header spiart_defs: state encodings S_RESET, S_IDLE, S_SETUP, S_START, S_WAIT, S_HOLD, S_GAP; the CS idle constant 2'b11.
- One sub-module, spi_arb_rr: the 2-way round-robin picker.
  - Inputs: the two request lines and last owner.
  - Outputs: grant valid and grant index.

## Test plan

- Reset while spi_busy is high, then release rst and pulse req0_start -> no grant until spi_busy falls; then spi_start high 2 cycles after start is seen.
- req0 alone sends 8'hA5 with the model echoing 8'h3C -> cs_n 2'b10 for the byte, req0_rx = 8'h3C when req0_busy falls, then cs_n 2'b11 for exactly 2 cycles.
- req0 and req1 start in the same cycle after reset -> req0 granted first, then req1. Repeat the simultaneous starts -> the other requester wins first, alternating.
- req1 sends 3 bytes 8'h01, 8'h02, 8'h03 with lock high while req0_start is held high -> cs_n[1] low continuously across all 3 bytes. req0 is granted only after lock drops plus GAP cycles.
- rst asserted in S_WAIT -> cs_n 2'b11, both busy 0 and spi_start 0 in the same cycle. Recovery via S_RESET once spi_busy falls.
- GAP=1 build -> single CS-high cycle between back-to-back unlocked transactions from alternating requesters.
